// File: rtl/garage_pkg.sv
// garage_pkg: shared sequencer types, grid dimensions and cell addressing
package garage_pkg;
  typedef enum logic [1:0] {STOP, PLAY, PAUSE} seq_state_t;
  typedef enum logic [1:0] {OP_TOGGLE, OP_SET, OP_CLEAR, OP_CLEAR_ALL} edit_op_t;
  localparam int NUM_ROWS = 4;
  localparam int NUM_STEPS = 8;
  function automatic logic [4:0] cell_addr(input logic [1:0] row, input logic [2:0] col);
    return {row, ~col};
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every TICK_DIV enabled cycles; ports CLK, RESET, en, clr -> tick
module tick_divider #(
  parameter int TICK_DIV = 381
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] r_div;
  assign tick = en && r_div == W'(TICK_DIV - 1);
  always_ff @(posedge CLK)
    if (RESET || clr) r_div <= '0;
    else if (en) r_div <= tick ? '0 : r_div + 1'b1;
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: 4x8 beat grid, transport FSM, playhead and per-row step triggers; ports CLK, RESET, start/pause/stop, edit_* -> pattern, count, step, trig, playing
module pattern_sequencer
  import garage_pkg::*;
#(
  parameter int TICK_DIV   = 381,
  parameter int STEP_TICKS = 16384,
  parameter int NUM_STEPS  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        edit_valid,
  input  logic [1:0]  edit_op,
  input  logic [1:0]  edit_row,
  input  logic [2:0]  edit_col,
  output logic [31:0] pattern,
  output logic [31:0] count,
  output logic [2:0]  step,
  output logic [3:0]  trig,
  output logic        playing
);
  localparam int IW = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
  localparam logic [31:0] CMAX = 32'(STEP_TICKS * NUM_STEPS - 1);
  seq_state_t r_state;
  logic [31:0] r_pattern, r_count, w_pat_nxt, w_bit;
  logic [IW-1:0] r_intra;
  logic [2:0] r_step, w_next_step, w_tstep;
  logic [3:0] r_trig, w_trig;
  logic r_playing, w_tick, w_en, w_clr, w_wrap, w_boundary;
  edit_op_t w_op;
  assign w_en = r_state == PLAY && !pause && !stop;
  assign w_clr = stop || (r_state == STOP && start);
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .CLK(CLK), .RESET(RESET), .en(w_en), .clr(w_clr), .tick(w_tick)
  );
  assign w_wrap = r_count == CMAX;
  assign w_boundary = r_intra == IW'(STEP_TICKS - 1);
  assign w_next_step = w_wrap ? 3'd0 : r_step + 3'(w_boundary);
  // start out of STOP enters step 0 regardless of where the intra counter sits
  assign w_tstep = r_state == STOP ? 3'd0 : w_next_step;
  assign w_op = edit_op_t'(edit_op);
  always_comb begin
    w_bit = 32'd1 << cell_addr(edit_row, edit_col);
    w_pat_nxt = !edit_valid ? r_pattern :
                w_op == OP_TOGGLE ? r_pattern ^ w_bit :
                w_op == OP_SET    ? r_pattern | w_bit :
                w_op == OP_CLEAR  ? r_pattern & ~w_bit : '0;
  end
  // triggers read the pre-edit pattern so a same-cycle edit never alters them
  always_comb begin
    w_trig = '0;
    for (int r = 0; r < NUM_ROWS; r++) w_trig[r] = r_pattern[cell_addr(2'(r), w_tstep)];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= STOP;
      r_pattern <= '0;
      r_count   <= '0;
      r_intra   <= '0;
      r_step    <= '0;
      r_trig    <= '0;
      r_playing <= 1'b0;
    end else begin
      r_pattern <= w_pat_nxt;
      r_trig    <= '0;
      if (stop) begin
        r_state   <= STOP;
        r_count   <= '0;
        r_intra   <= '0;
        r_step    <= '0;
        r_playing <= 1'b0;
      end else if (pause) begin
        if (r_state == PLAY) begin
          r_state   <= PAUSE;
          r_playing <= 1'b0;
        end
      end else if (start && r_state != PLAY) begin
        r_state   <= PLAY;
        r_playing <= 1'b1;
        if (r_state == STOP) r_trig <= w_trig;
      end else if (w_tick) begin
        r_count <= w_wrap ? '0 : r_count + 1'b1;
        r_intra <= (w_wrap || w_boundary) ? '0 : r_intra + 1'b1;
        r_step  <= w_next_step;
        if (w_wrap || w_boundary) r_trig <= w_trig;
      end
    end
  end
  assign pattern = r_pattern;
  assign count   = r_count;
  assign step    = r_step;
  assign trig    = r_trig;
  assign playing = r_playing;
endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Step sequencer that owns the 4-row × 8-step beat grid and the playhead. It accepts cell-edit commands and transport commands (start/pause/stop), and holds the 32-bit `pattern` and the `count` playhead consumed by the VGA sprite renderer. It also emits one-cycle per-row note triggers at each step boundary for the audio voices. Cell bit mapping matches the renderer: bit = 8·row + (7 − col).

## Interface
Parameters:
- `TICK_DIV`, default 381: clock cycles per playhead tick; must be ≥ 1.
- `STEP_TICKS`, default 16384: ticks per step.
- `NUM_STEPS`, default 8: steps per loop; fixed at 8 for the 32-bit pattern.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high.
- `start` in 1: pulse; start or resume playback.
- `pause` in 1: pulse; hold the playhead.
- `stop` in 1: pulse; halt and rewind to 0.
- `edit_valid` in 1: pulse; apply the edit described by `edit_op`, `edit_row`, `edit_col` this cycle.
- `edit_op` in 2: 00 toggle, 01 set, 10 clear cell, 11 clear all (row/col ignored).
- `edit_row` in 2: row 0–3.
- `edit_col` in 3: column/step 0–7.
- `pattern` out 32: grid register.
- `count` out 32: playhead, 0 … STEP_TICKS·NUM_STEPS−1 (131071 at defaults).
- `step` out 3: current step = count / STEP_TICKS.
- `trig` out 4: one-cycle pulse per row with a set cell at the newly entered step.
- `playing` out 1: high in state PLAY.

## Operation
- FSM states: STOP, PLAY, PAUSE.
- Reset enters STOP. All outputs are 0 and the divider is 0.
- Command priority in one cycle: stop > pause > start.
- STOP:
  - `start` → PLAY; the divider clears.
  - Step 0 is "entered", so `trig` fires for step 0.
- PLAY:
  - Divider runs 0 … TICK_DIV−1.
  - When divider == TICK_DIV−1, `count` increments, wrapping from max to 0.
  - `pause` → PAUSE. `stop` → STOP.
  - `start` in PLAY is ignored.
- PAUSE:
  - Divider and `count` hold.
  - `start` → PLAY and resumes from the held state; no `trig` on resume.
  - `stop` → STOP.
- STOP entry from any state: `count`, `step` and divider go to 0; no `trig`; `pattern` is retained.
- Step boundary: a `count` update whose new value is a multiple of STEP_TICKS, including the wrap to 0.
- Trigger value: `trig[r] = pattern[8·r + 7 − new_step]`, using the pattern register value before that clock edge.
- Edits:
  - Applied at the edge where `edit_valid` = 1. Accepted in every state, including while RESET is low and in the same cycle as a transport command.
  - `edit_valid` during RESET is discarded.
  - Toggle, set and clear affect a single bit. Clear all zeroes all 32 bits.
- Edit/trigger collision: an edit to the cell being triggered in the same cycle as its step boundary does not affect that `trig`; the stored bit does change.
- Width rules:
  - `count` is a 32-bit unsigned register; its comparison against max is exact.
  - `step` is derived from `count` using a separate step counter plus an intra-step counter, so no divider is needed.

## Timing
- All outputs are registered.
- `pattern` reflects an edit one cycle after `edit_valid`.
- Tick cadence:
  - From `start` accepted at edge N out of STOP, `count` first becomes 1 at edge N + TICK_DIV.
  - Each subsequent tick follows TICK_DIV cycles later.
- `trig` alignment:
  - A pulse is high for exactly the cycle in which `count`/`step` first show the new step value. It is never high two consecutive cycles unless TICK_DIV·STEP_TICKS = 1.
  - Start-from-STOP `trig` is high in the cycle after `start` (at `count` = 0).
- `playing` changes one cycle after the command.
- RESET mid-play: on the next edge, all outputs are 0, the state is STOP, and `pattern` is cleared.

## Structure
- Shared package `garage_pkg`:
  - `seq_state_t` enum (STOP, PLAY, PAUSE).
  - `edit_op_t` enum.
  - `NUM_ROWS` = 4 and `NUM_STEPS` = 8.
  - Function `cell_addr(row, col)` returning 8·row + 7 − col, shared with the sprite renderer.
- Sub-module `tick_divider`:
  - Parameter `TICK_DIV`.
  - Ports: `CLK`, `RESET`, `en`, `clr`, `tick`.
  - Produces a one-cycle `tick` at divider == TICK_DIV−1 while `en` is high.

## Test plan
Parameters for all scenarios: TICK_DIV = 2, STEP_TICKS = 4 (loop of 32 ticks).
1. Reset, then check outputs: everything 0, `playing` = 0. Then toggle row 0/col 0 and set row 3/col 7 → `pattern` = 0x0100_0080 the cycle after the last edit.
2. With `pattern` = 0x8000_0000 (row 3, step 0 set):
   - Pulse `start` → `trig` = 4'b1000 the next cycle with `count` = 0.
   - Then `count` = 1 two cycles later.
   - Then `step` = 1 and `trig` = 0 at `count` = 4.
3. Wrap: run the full loop → `count` goes 31 → 0, `step` = 0, and `trig` repeats 4'b1000 exactly on the wrap cycle.
4. Pause at `count` = 9, wait 20 cycles → `count` holds at 9. Then `start` → `count` = 10 after two cycles, with no `trig` on resume.
5. Same cycle `stop` + `start` + clear-all edit → state STOP, `count` = 0, `pattern` = 0, no `trig`.
6. Toggle of row 0/step 2 in the cycle `count` enters 8 while the bit is 0 → `trig[0]` = 0 and `pattern` bit 5 = 1 afterward. RESET asserted mid-play → all outputs 0 on the next edge.
